// File: rtl/cpu_bus_target.sv
// Bus responder for the 2A03 core: mirrored 2 KiB RAM, 8 KiB WRAM with wait states,
// two serial controller ports at $4016/$4017, and open-bus retention.
module cpu_bus_target #(
   parameter int WAIT_CLOCKS = 6
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic [15:0] I_addr,
   input  logic [7:0]  I_wr_data,
   input  logic        I_rdwr,
   input  logic        I_phy2,
   output logic [7:0]  O_rd_data,
   output logic        O_ready,
   input  logic [7:0]  I_pad0,
   input  logic [7:0]  I_pad1,
   output logic        O_strobe
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(WAIT_CLOCKS - 1);
   localparam bit         LP_WAIT_EN  = (WAIT_CLOCKS != 0);

   logic       r_phy2_q;
   state_t     r_state;
   logic [3:0] r_cnt;
   logic [7:0] r_shift0;
   logic [7:0] r_shift1;
   logic [7:0] r_open_bus;
   logic [7:0] r_ram  [0:2047];
   logic [7:0] r_wram [0:8191];

   logic       w_rise;
   logic       w_fall;
   logic       w_is_ram;
   logic       w_is_wram;
   logic       w_is_p0;
   logic       w_is_p1;
   logic [7:0] w_rd_mux;

   assign w_rise    = I_phy2 & ~r_phy2_q;
   assign w_fall    = ~I_phy2 & r_phy2_q;
   assign w_is_ram  = (I_addr[15:13] == 3'b000);
   assign w_is_wram = (I_addr[15:13] == 3'b011);
   assign w_is_p0   = (I_addr == 16'h4016);
   assign w_is_p1   = (I_addr == 16'h4017);

   // Controller ports drive only D0; the upper bits read back as $40.
   always_comb begin
      w_rd_mux = r_open_bus;
      if (w_is_ram)       w_rd_mux = r_ram[I_addr[10:0]];
      else if (w_is_wram) w_rd_mux = r_wram[I_addr[12:0]];
      else if (w_is_p0)   w_rd_mux = {7'b0100_000, r_shift0[0]};
      else if (w_is_p1)   w_rd_mux = {7'b0100_000, r_shift1[0]};
   end

   // NOTE: the RAM arrays have no reset so they map onto plain memory; contents survive I_reset.
   always_ff @(posedge I_clock) begin
      if (w_fall && !I_rdwr) begin
         if (w_is_ram)  r_ram[I_addr[10:0]]  <= I_wr_data;
         if (w_is_wram) r_wram[I_addr[12:0]] <= I_wr_data;
      end
   end

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         r_phy2_q   <= 1'b0;
         O_rd_data  <= 8'h00;
         O_strobe   <= 1'b0;
         r_shift0   <= 8'h00;
         r_shift1   <= 8'h00;
         r_open_bus <= 8'h00;
      end else begin
         r_phy2_q <= I_phy2;
         if (w_rise && I_rdwr)
            O_rd_data <= w_rd_mux;
         if (w_fall)
            r_open_bus <= I_rdwr ? O_rd_data : I_wr_data;
         if (w_fall && !I_rdwr && w_is_p0)
            O_strobe <= I_wr_data[0];
         // A held strobe keeps reloading the pads, which overrides any read shift.
         if (O_strobe) begin
            r_shift0 <= I_pad0;
            r_shift1 <= I_pad1;
         end else if (w_fall && I_rdwr) begin
            if (w_is_p0) r_shift0 <= {1'b1, r_shift0[7:1]};
            if (w_is_p1) r_shift1 <= {1'b1, r_shift1[7:1]};
         end
      end
   end

   // Wait-state FSM: O_ready is low for exactly WAIT_CLOCKS clocks after a WRAM rise.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         O_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise && w_is_wram && LP_WAIT_EN) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= LP_CNT_INIT;
                  O_ready <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_IDLE;
                  O_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               O_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_bus_target.sv
// Directed bench for cpu_bus_target; the bench plays the 2A03 core, freezing its
// phy2 tick whenever O_ready is low.
module tb_cpu_bus_target;

   logic        I_clock = 1'b0;
   logic        I_reset;
   logic [15:0] I_addr;
   logic [7:0]  I_wr_data;
   logic        I_rdwr;
   logic        I_phy2;
   logic [7:0]  O_rd_data;
   logic        O_ready;
   logic [7:0]  I_pad0;
   logic [7:0]  I_pad1;
   logic        O_strobe;

   int total = 0;
   int bad   = 0;

   cpu_bus_target #(.WAIT_CLOCKS(6)) dut (
      .I_clock  (I_clock),
      .I_reset  (I_reset),
      .I_addr   (I_addr),
      .I_wr_data(I_wr_data),
      .I_rdwr   (I_rdwr),
      .I_phy2   (I_phy2),
      .O_rd_data(O_rd_data),
      .O_ready  (O_ready),
      .I_pad0   (I_pad0),
      .I_pad1   (I_pad1),
      .O_strobe (O_strobe)
   );

   always #5 I_clock = ~I_clock;

   // One core bus cycle: 2 clocks phy2 low, then phy2 high for 6 core ticks; a tick
   // only advances on a clock edge that sees O_ready=1. Entered and left on a negedge.
   task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                            output logic [7:0] rd, output int low_cnt,
                            output int first_low, output int high_len);
      int   ticks;
      logic rdy_seen;
      I_addr    = a;
      I_rdwr    = rw;
      I_wr_data = wd;
      I_phy2    = 1'b0;
      repeat (2) @(negedge I_clock);
      I_phy2    = 1'b1;
      ticks     = 0;
      high_len  = 0;
      low_cnt   = 0;
      first_low = -1;
      while (ticks < 6 && high_len < 64) begin
         rdy_seen = O_ready;
         @(negedge I_clock);
         high_len++;
         if (rdy_seen) ticks++;
         if (!O_ready) begin
            low_cnt++;
            if (first_low < 0) first_low = high_len;
         end
      end
      rd     = O_rd_data;
      I_phy2 = 1'b0;
      @(negedge I_clock);
   endtask

   task automatic test_reset;
      logic [7:0] rd;
      int lc, fl, hl;
      total++;
      if (O_rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", O_rd_data); end
      total++;
      if (O_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", O_ready); end
      total++;
      if (O_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", O_strobe); end
      bus_cycle(16'h5000, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h00) begin bad++; $display("FAIL reset_open_bus: got %h want 00", rd); end
   endtask

   task automatic test_ram_mirror;
      logic [15:0] addrs [3] = '{16'h0923, 16'h1123, 16'h1923};
      logic [7:0] rd;
      int lc, fl, hl;
      bus_cycle(16'h0123, 1'b0, 8'h5A, rd, lc, fl, hl);
      total++;
      if (lc !== 0) begin bad++; $display("FAIL mirror_write_ready: low clocks %0d want 0", lc); end
      foreach (addrs[i]) begin
         bus_cycle(addrs[i], 1'b1, 8'h00, rd, lc, fl, hl);
         total++;
         if (rd !== 8'h5A) begin bad++; $display("FAIL mirror_read_%h: got %h want 5a", addrs[i], rd); end
         total++;
         if (lc !== 0 || hl !== 6) begin
            bad++; $display("FAIL mirror_ready_%h: low %0d high %0d want 0/6", addrs[i], lc, hl);
         end
      end
   endtask

   task automatic test_wrap;
      logic [7:0] rd;
      int lc, fl, hl;
      bus_cycle(16'h0800, 1'b0, 8'hE1, rd, lc, fl, hl);
      bus_cycle(16'h0000, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'hE1) begin bad++; $display("FAIL wrap_0800_to_0000: got %h want e1", rd); end
      bus_cycle(16'h07FF, 1'b0, 8'h9C, rd, lc, fl, hl);
      bus_cycle(16'h1FFF, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h9C) begin bad++; $display("FAIL wrap_1fff: got %h want 9c", rd); end
      bus_cycle(16'hFFFF, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h9C) begin bad++; $display("FAIL unmapped_ffff: got %h want 9c", rd); end
   endtask

   task automatic test_controller;
      logic [7:0] exp [10] = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
      logic [7:0] rd;
      int lc, fl, hl;
      I_pad0 = 8'b1000_0101;
      bus_cycle(16'h4016, 1'b0, 8'h01, rd, lc, fl, hl);
      total++;
      if (O_strobe !== 1'b1) begin bad++; $display("FAIL strobe_set: got %b want 1", O_strobe); end
      bus_cycle(16'h4016, 1'b0, 8'h00, rd, lc, fl, hl);
      total++;
      if (O_strobe !== 1'b0) begin bad++; $display("FAIL strobe_clear: got %b want 0", O_strobe); end
      I_pad0 = 8'h00;
      foreach (exp[i]) begin
         bus_cycle(16'h4016, 1'b1, 8'h00, rd, lc, fl, hl);
         total++;
         if (rd !== exp[i]) begin bad++; $display("FAIL pad0_read_%0d: got %h want %h", i, rd, exp[i]); end
      end
   endtask

   task automatic test_strobe_high;
      logic [7:0] rd;
      int lc, fl, hl;
      I_pad1 = 8'h01;
      I_pad0 = 8'h00;
      bus_cycle(16'h4016, 1'b0, 8'h01, rd, lc, fl, hl);
      for (int i = 0; i < 3; i++) begin
         bus_cycle(16'h4017, 1'b1, 8'h00, rd, lc, fl, hl);
         total++;
         if (rd !== 8'h41) begin bad++; $display("FAIL strobe_pad1_read_%0d: got %h want 41", i, rd); end
      end
      bus_cycle(16'h4016, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h40) begin bad++; $display("FAIL strobe_pad0_read: got %h want 40", rd); end
      bus_cycle(16'h4016, 1'b0, 8'h00, rd, lc, fl, hl);
   endtask

   task automatic test_wait_states;
      logic [7:0] rd;
      int lc, fl, hl;
      bus_cycle(16'h6010, 1'b0, 8'hC3, rd, lc, fl, hl);
      total++;
      if (lc !== 6 || fl !== 1 || hl !== 12) begin
         bad++; $display("FAIL wram_write_wait: low %0d first %0d high %0d want 6/1/12", lc, fl, hl);
      end
      bus_cycle(16'h6010, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'hC3) begin bad++; $display("FAIL wram_read: got %h want c3", rd); end
      total++;
      if (lc !== 6 || fl !== 1 || hl !== 12) begin
         bad++; $display("FAIL wram_read_wait: low %0d first %0d high %0d want 6/1/12", lc, fl, hl);
      end
   endtask

   task automatic test_open_bus;
      logic [7:0] rd;
      int lc, fl, hl;
      bus_cycle(16'h0000, 1'b0, 8'h77, rd, lc, fl, hl);
      bus_cycle(16'h5000, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h77) begin bad++; $display("FAIL open_bus_5000: got %h want 77", rd); end
      bus_cycle(16'h4020, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h77) begin bad++; $display("FAIL open_bus_4020: got %h want 77", rd); end
   endtask

   task automatic test_reset_mid_wait;
      logic [7:0] rd;
      int lc, fl, hl;
      bus_cycle(16'h4016, 1'b0, 8'h01, rd, lc, fl, hl);
      I_addr = 16'h6010;
      I_rdwr = 1'b1;
      repeat (2) @(negedge I_clock);
      I_phy2 = 1'b1;
      repeat (4) @(negedge I_clock);
      total++;
      if (O_ready !== 1'b0) begin bad++; $display("FAIL mid_wait_ready_low: got %b want 0", O_ready); end
      #2 I_reset = 1'b0;
      #1;
      total++;
      if (O_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready: got %b want 1", O_ready); end
      total++;
      if (O_rd_data !== 8'h00) begin bad++; $display("FAIL async_reset_rd_data: got %h want 00", O_rd_data); end
      total++;
      if (O_strobe !== 1'b0) begin bad++; $display("FAIL async_reset_strobe: got %b want 0", O_strobe); end
      I_phy2 = 1'b0;
      @(negedge I_clock);
      @(negedge I_clock);
      I_reset = 1'b1;
      @(negedge I_clock);
      bus_cycle(16'h0000, 1'b1, 8'h00, rd, lc, fl, hl);
      total++;
      if (rd !== 8'h77) begin bad++; $display("FAIL ram_kept_after_reset: got %h want 77", rd); end
      total++;
      if (lc !== 0) begin bad++; $display("FAIL ready_after_reset: low clocks %0d want 0", lc); end
   endtask

   initial begin
      I_reset   = 1'b0;
      I_addr    = 16'h0000;
      I_wr_data = 8'h00;
      I_rdwr    = 1'b1;
      I_phy2    = 1'b0;
      I_pad0    = 8'h00;
      I_pad1    = 8'h00;
      repeat (3) @(negedge I_clock);
      I_reset = 1'b1;
      @(negedge I_clock);
      test_reset;
      test_ram_mirror;
      test_wrap;
      test_controller;
      test_strobe_high;
      test_wait_states;
      test_open_bus;
      test_reset_mid_wait;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_bus_target.md
# cpu_bus_target

Bus responder on the 2A03 core's external bus: the core initiates every access, and this block answers it. It decodes the address, serves 2 KiB of mirrored internal RAM and 8 KiB of work RAM, and implements the two serial controller ports at $4016/$4017. It inserts wait states on the work-RAM window by pulling the core's ready input low, and it holds the open-bus value. It sits between the core's O_addr/O_wr_data/O_rdwr/O_phy2 outputs and its I_rd_data/I_ready inputs.

## Interface
- WAIT_CLOCKS, 6: I_clock cycles for which O_ready is held low on each $6000-$7FFF access; 0 disables wait states (range 0-15).
- I_clock  in  1  system clock, same clock as the core.
- I_reset  in  1  reset. One clock; reset is asynchronous and active-low.
- I_addr  in  16  core O_addr.
- I_wr_data  in  8  core O_wr_data.
- I_rdwr  in  1  core O_rdwr: 1 = read, 0 = write.
- I_phy2  in  1  core O_phy2; the bus phase is high while the core's tick is 6..11.
- O_rd_data  out  8  to core I_rd_data; registered.
- O_ready  out  1  to core I_ready; 1 = proceed.
- I_pad0  in  8  controller 1 buttons, bit0 = A … bit7 = Right, 1 = pressed.
- I_pad1  in  8  controller 2 buttons, same encoding.
- O_strobe  out  1  current controller strobe latch.

## Operation
- Edge detect: phy2_q is I_phy2 registered. rise = I_phy2 & ~phy2_q. fall = ~I_phy2 & phy2_q.
- fall coincides with the clock on which the core latches its registers. Address and write data are still valid at fall.
- Address map:
  - $0000-$1FFF: RAM, index addr[10:0], mirrored 4×.
  - $4016: port 0.
  - $4017: port 1.
  - $6000-$7FFF: WRAM, index addr[12:0].
  - Everything else is unmapped.
- Read path, at rise with I_rdwr=1, O_rd_data is loaded from:
  - RAM or WRAM: the array word at the decoded index.
  - $4016/$4017: 8'h40 | shift0[0] / shift1[0].
  - Unmapped: the open-bus register.
- Write path: at fall with I_rdwr=0:
  - RAM or WRAM: write I_wr_data to the decoded index.
  - $4016: O_strobe <= I_wr_data[0].
  - $4017 writes and unmapped writes are ignored.
- Open bus: at fall, the open-bus register is loaded with O_rd_data on reads and with I_wr_data on writes.
- Controller shift registers:
  - While O_strobe=1, shift0 <= I_pad0 and shift1 <= I_pad1 on every clock.
  - While O_strobe=0, a read of $4016 committed at fall shifts shift0 right with 1 entering bit7. $4017 does the same for shift1.
  - Each access shifts exactly once, including the core's dummy reads.
- Wait-state FSM:
  - States are IDLE and WAIT.
  - IDLE → WAIT at rise when addr is in $6000-$7FFF and WAIT_CLOCKS≠0. On entry: O_ready <= 0, cnt <= WAIT_CLOCKS-1.
  - In WAIT, cnt decrements every clock. At cnt=0: O_ready <= 1, return to IDLE.
  - While O_ready=0 the core's tick is frozen, so I_phy2 stays high and no second rise occurs. There is exactly one wait burst per access.

## Timing
- Reset values:
  - O_rd_data=8'h00, O_ready=1, O_strobe=0.
  - shift0, shift1, open bus, cnt: 0. phy2_q=0. FSM in IDLE.
  - RAM and WRAM contents are not cleared.
- Read latency: O_rd_data is valid one I_clock after rise and stable until the next rise. It is always valid before fall, because phy2 is high for ≥6 clocks.
- Wait states:
  - O_ready goes low on the clock after rise and stays low for exactly WAIT_CLOCKS clocks.
  - The access's phy2-high phase is lengthened by WAIT_CLOCKS clocks.
- Reset asserted mid-wait: O_ready returns to 1 immediately and asynchronously, and the FSM goes to IDLE.
- Strobe change: the strobe-driven reload starts on the clock after the $4016 write commits at fall.
- Simultaneous events:
  - A $4016 read with O_strobe=1: the read returns I_pad0[0] as loaded. There is no shift, because the reload wins.
  - A pad input changing on the same clock as rise: rise samples the registered shift value.
- Wrap: $07FF+1 mirrors to $0800, which maps to index 0. An access to $FFFF is unmapped and returns open bus.

## Test plan
- RAM mirror: write $5A to $0123, then read $0923, $1123 and $1923. Each read returns $5A, and O_ready stays 1 throughout.
- Controller read:
  - Setup: I_pad0=8'b1000_0101. Write $4016=$01, then $4016=$00.
  - Read $4016 ten times. The reads return $41,$40,$41,$40,$40,$40,$40,$41,$41,$41.
- Wait states, WAIT_CLOCKS=6:
  - Write $C3 to $6010 and read it back. The read returns $C3.
  - Each access shows O_ready low for exactly 6 clocks, starting 1 clock after rise. I_phy2 is high for 12 clocks.
- Open bus: write $77 to $0000, then read $5000. The read returns $77. A following read of $4020 also returns $77.
- Reset mid-wait: assert I_reset=0 three clocks into a WRAM wait. O_ready=1, O_rd_data=$00 and O_strobe=0 are all immediate. After release, a read of $0000 returns the pre-reset RAM content.
- Strobe held high: with O_strobe=1 and I_pad1=$01, read $4017 three times. Every read returns $41.
